mod_n_updown_counter: RTL and testbench
=======================================

// Module: mod_n_updown_counter
//
// PURPOSE
//   Parametrised modulo-N synchronous up/down counter. It is the next generation of the
//   4-bit ripple counter and is fully synchronous (no ripple clocks).
//   Adds count enable, direction control, parallel load, and a terminal-count output.
//   Adds a sticky overflow flag and an optional saturating mode.
//   It is the general-purpose counter for the timer, divider and sequencer blocks.
//
// PARAMETERS
//   WIDTH      4   counter width in bits
//   MOD_VALUE  16  modulus; count range 0..MOD_VALUE-1. Legal range 2 <= MOD_VALUE <= 2**WIDTH.
//   SATURATE   0   0 = wrap at limits; 1 = hold at limits (no wrap)
//
// PORTS
//   clk       input   1      clock; all state updates on rising edge
//   reset     input   1      synchronous, active-high reset
//   en        input   1      count enable
//   up_dn     input   1      direction: 1 = count up, 0 = count down
//   load      input   1      parallel load strobe
//   load_val  input   WIDTH  value to load
//   q         output  WIDTH  current count (registered)
//   tc        output  1      terminal count (combinational from q/en/up_dn)
//   ovf       output  1      sticky overflow/underflow flag (registered)
//
// BEHAVIOUR
//   - MAX = MOD_VALUE-1. An elaboration-time check rejects MOD_VALUE<2 or MOD_VALUE>2**WIDTH.
//   - Reset (synchronous): q=0, ovf=0 on the next edge. tc follows from q=0.
//   - Priority per edge: reset > load > en. up_dn is sampled every enabled edge.
//   - load=1: q <= min(load_val, MAX), so values >= MOD_VALUE clamp to MAX.
//     load also clears ovf. load ignores en.
//   - en=1, load=0, up_dn=1:
//       q<MAX       -> q+1
//       q==MAX      -> 0 (SATURATE=0) or hold MAX (SATURATE=1)
//   - en=1, load=0, up_dn=0:
//       q>0         -> q-1
//       q==0        -> MAX (SATURATE=0) or hold 0 (SATURATE=1)
//   - en=0, load=0: q holds. ovf holds.
//   - tc = en & ((up_dn & q==MAX) | (~up_dn & q==0)). It is 0 when en=0.
//     tc is asserted in the same cycle that the boundary edge is taken.
//   - ovf: set on any edge where tc=1 and load=0. This covers both wrap and
//     saturate-hold. Once set, ovf stays 1 until reset or load.
//   - Simultaneous events:
//       load & tc: load wins and ovf clears.
//       reset with anything: reset wins.
//   - Direction change mid-count takes effect on the next enabled edge, with no lost count.
//   - Latency: q changes one clk after the qualifying inputs. No other pipeline.
//   - All outputs are known (no X) from the first edge after reset.
//
// TESTING (bench uses WIDTH=4, MOD_VALUE=10 unless noted)
//   1. Assert reset for 2 clk, then en=1, up_dn=1 for 12 clk
//      -> q = 0,1..9,0,1; tc=1 only while q=9; ovf rises on the edge after q=9 and stays 1.
//   2. From reset, en=1, up_dn=0 -> q = 0,9,8,7; tc=1 while q=0; ovf=1 after the first edge.
//   3. load=1, load_val=7 with en=1 -> q=7 next edge, ovf=0.
//      Then load_val=12 -> q=9 (clamped).
//   4. Counting up at q=4, set en=0 for 3 clk -> q holds 4, tc=0.
//      Then en=1, up_dn=0 -> q=3,2.
//   5. SATURATE=1: count up from 8 -> q=9,9,9 with ovf=1.
//      Then count down from 1 -> q=0,0 with tc=1.
//   6. At q=5, assert reset and load together (load_val=3) -> q=0, ovf=0 on the next edge.

Source files
------------

// File: rtl/mod_n_updown_counter_if.sv
// Control/status bundle for mod_n_updown_counter: the master drives the
// count controls, the slave (the counter) returns count, terminal count and overflow.
interface mod_n_updown_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             ovf;

   modport master (
      output en, up_dn, load, load_val,
      input  q, tc, ovf
   );

   modport slave (
      input  en, up_dn, load, load_val,
      output q, tc, ovf
   );
endinterface

// File: rtl/mod_n_updown_counter.sv
// Fully synchronous modulo-N up/down counter with parallel load, terminal
// count, sticky overflow/underflow flag and optional saturation at the limits.
module mod_n_updown_counter #(
   parameter int WIDTH     = 4,
   parameter int MOD_VALUE = 16,
   parameter int SATURATE  = 0
) (
   input logic                  clk,
   input logic                  reset,
   mod_n_updown_counter_if.slave bus
);

   if (MOD_VALUE < 2 || MOD_VALUE > 2**WIDTH) begin : g_bad_mod
      $error("mod_n_updown_counter: MOD_VALUE must satisfy 2 <= MOD_VALUE <= 2**WIDTH");
   end

   localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD_VALUE - 1);

   logic [WIDTH-1:0] q_r;
   logic             ovf_r;
   logic             tc;
   logic [WIDTH-1:0] load_clamped;

   // tc flags the edge on which the count crosses (or sticks at) a limit.
   assign tc = bus.en & ((bus.up_dn & (q_r == MAX)) | (~bus.up_dn & (q_r == '0)));

   assign load_clamped = (bus.load_val > MAX) ? MAX : bus.load_val;

   always_ff @(posedge clk) begin
      if (reset) begin
         q_r   <= '0;
         ovf_r <= 1'b0;
      end else if (bus.load) begin
         q_r   <= load_clamped;
         ovf_r <= 1'b0;
      end else if (bus.en) begin
         if (tc) begin
            ovf_r <= 1'b1;
            if (SATURATE == 0) begin
               q_r <= bus.up_dn ? '0 : MAX;
            end
         end else if (bus.up_dn) begin
            q_r <= q_r + 1'b1;
         end else begin
            q_r <= q_r - 1'b1;
         end
      end
   end

   assign bus.q   = q_r;
   assign bus.tc  = tc;
   assign bus.ovf = ovf_r;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Directed bench for mod_n_updown_counter (WIDTH=4, MOD_VALUE=10): a wrapping
// instance checked from a vector table and a saturating instance checked by hand.
module tb_mod_n_updown_counter;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         en;
   logic         up_dn;
   logic         load;
   logic [W-1:0] load_val;

   int n_checks = 0;
   int n_errors = 0;

   mod_n_updown_counter_if #(.WIDTH(W)) bus_w ();
   mod_n_updown_counter_if #(.WIDTH(W)) bus_s ();

   assign bus_w.en       = en;
   assign bus_w.up_dn    = up_dn;
   assign bus_w.load     = load;
   assign bus_w.load_val = load_val;
   assign bus_s.en       = en;
   assign bus_s.up_dn    = up_dn;
   assign bus_s.load     = load;
   assign bus_s.load_val = load_val;

   mod_n_updown_counter #(.WIDTH(W), .MOD_VALUE(10), .SATURATE(0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_w)
   );

   mod_n_updown_counter #(.WIDTH(W), .MOD_VALUE(10), .SATURATE(1)) dut_sat (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_s)
   );

   // clock / reset
   always #5 clk = ~clk;

   // One vector: inputs held for one edge; expected outputs are the values
   // seen with those inputs applied, just before that edge.
   typedef struct {
      logic         rst;
      logic         en;
      logic         ud;
      logic         ld;
      logic [W-1:0] lv;
      logic         chk;
      logic [W-1:0] q;
      logic         tc;
      logic         ovf;
      string        name;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic e, input logic u, input logic l,
                      input logic [W-1:0] v, input logic c, input logic [W-1:0] eq,
                      input logic et, input logic eo, input string nm);
      vec_t t;
      t.rst = r; t.en = e; t.ud = u; t.ld = l; t.lv = v;
      t.chk = c; t.q = eq; t.tc = et; t.ovf = eo; t.name = nm;
      vecs.push_back(t);
   endtask

   // driver tasks
   task automatic set_in(input logic r, input logic e, input logic u, input logic l,
                         input logic [W-1:0] v);
      reset = r; en = e; up_dn = u; load = l; load_val = v;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // scoreboard compare
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   initial begin
      set_in(1'b1, 1'b0, 1'b0, 1'b0, '0);

      // Test 1: reset 2 clk, then count up 12 clk
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, "rst0");
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, "rst1");
      for (int i = 0; i < 12; i++)
         add(0, 1, 1, 0, 0, 1, W'(i % 10), (i == 9), (i >= 10), $sformatf("up%0d", i));
      // Test 2: reset, then count down through the wrap
      add(1, 0, 0, 0, 0, 1, 2, 0, 1, "t2_rst");
      add(0, 1, 0, 0, 0, 1, 0, 1, 0, "t2_dn0");
      add(0, 1, 0, 0, 0, 1, 9, 0, 1, "t2_dn9");
      add(0, 1, 0, 0, 0, 1, 8, 0, 1, "t2_dn8");
      add(0, 1, 0, 0, 0, 1, 7, 0, 1, "t2_dn7");
      // Test 3: load, clamp, load colliding with tc
      add(0, 1, 0, 1, 7,  1, 6, 0, 1, "t3_ld7");
      add(0, 1, 1, 1, 12, 1, 7, 0, 0, "t3_ld12");
      add(0, 0, 1, 0, 0,  1, 9, 0, 0, "t3_clamp");
      add(0, 1, 1, 1, 4,  1, 9, 1, 0, "t3_ld_tc");
      // Test 4: hold with en=0, then reverse direction
      add(0, 0, 1, 0, 0, 1, 4, 0, 0, "t4_hold0");
      add(0, 0, 1, 0, 0, 1, 4, 0, 0, "t4_hold1");
      add(0, 0, 1, 0, 0, 1, 4, 0, 0, "t4_hold2");
      add(0, 1, 0, 0, 0, 1, 4, 0, 0, "t4_dn4");
      add(0, 1, 0, 0, 0, 1, 3, 0, 0, "t4_dn3");
      // Test 6: walk down to 5 with ovf set, then reset+load together
      add(0, 1, 0, 0, 0, 1, 2, 0, 0, "t6_dn2");
      add(0, 1, 0, 0, 0, 1, 1, 0, 0, "t6_dn1");
      add(0, 1, 0, 0, 0, 1, 0, 1, 0, "t6_dn0");
      add(0, 1, 0, 0, 0, 1, 9, 0, 1, "t6_dn9");
      add(0, 1, 0, 0, 0, 1, 8, 0, 1, "t6_dn8");
      add(0, 1, 0, 0, 0, 1, 7, 0, 1, "t6_dn7");
      add(0, 1, 0, 0, 0, 1, 6, 0, 1, "t6_dn6");
      add(1, 1, 0, 1, 3, 1, 5, 0, 1, "t6_rst_ld");
      add(0, 0, 0, 1, 10, 1, 0, 0, 0, "t6_after");
      add(0, 1, 1, 0, 0,  1, 9, 1, 0, "ld10_clamp");

      @(negedge clk);
      foreach (vecs[i]) begin
         set_in(vecs[i].rst, vecs[i].en, vecs[i].ud, vecs[i].ld, vecs[i].lv);
         #1;
         if (vecs[i].chk) begin
            chk({vecs[i].name, ".q"},   32'(bus_w.q),   32'(vecs[i].q));
            chk({vecs[i].name, ".tc"},  32'(bus_w.tc),  32'(vecs[i].tc));
            chk({vecs[i].name, ".ovf"}, 32'(bus_w.ovf), 32'(vecs[i].ovf));
         end
         tick();
      end
      #1;
      chk("end.q",   32'(bus_w.q),   32'd0);
      chk("end.ovf", 32'(bus_w.ovf), 32'd1);

      // Test 5: saturating instance holds at the limits
      set_in(1, 0, 0, 0, 0); tick();
      set_in(0, 0, 0, 1, 8); #1;
      chk("s_rst.q",   32'(bus_s.q),   32'd0);
      chk("s_rst.ovf", 32'(bus_s.ovf), 32'd0);
      tick();
      set_in(0, 1, 1, 0, 0); #1;
      chk("s_up8.q",  32'(bus_s.q),  32'd8);
      chk("s_up8.tc", 32'(bus_s.tc), 32'd0);
      tick(); #1;
      chk("s_up9.q",   32'(bus_s.q),   32'd9);
      chk("s_up9.tc",  32'(bus_s.tc),  32'd1);
      chk("s_up9.ovf", 32'(bus_s.ovf), 32'd0);
      chk("w_up9.q",   32'(bus_w.q),   32'd9);
      chk("w_up9.tc",  32'(bus_w.tc),  32'd1);
      tick(); #1;
      chk("s_hold9a.q",   32'(bus_s.q),   32'd9);
      chk("s_hold9a.tc",  32'(bus_s.tc),  32'd1);
      chk("s_hold9a.ovf", 32'(bus_s.ovf), 32'd1);
      chk("w_wrap.q",     32'(bus_w.q),   32'd0);
      chk("w_wrap.ovf",   32'(bus_w.ovf), 32'd1);
      tick(); #1;
      chk("s_hold9b.q",   32'(bus_s.q),   32'd9);
      chk("s_hold9b.ovf", 32'(bus_s.ovf), 32'd1);
      set_in(0, 0, 0, 1, 1); tick();
      set_in(0, 1, 0, 0, 0); #1;
      chk("s_dn1.q",   32'(bus_s.q),   32'd1);
      chk("s_dn1.tc",  32'(bus_s.tc),  32'd0);
      chk("s_dn1.ovf", 32'(bus_s.ovf), 32'd0);
      tick(); #1;
      chk("s_dn0a.q",   32'(bus_s.q),   32'd0);
      chk("s_dn0a.tc",  32'(bus_s.tc),  32'd1);
      chk("s_dn0a.ovf", 32'(bus_s.ovf), 32'd0);
      tick(); #1;
      chk("s_dn0b.q",   32'(bus_s.q),   32'd0);
      chk("s_dn0b.tc",  32'(bus_s.tc),  32'd1);
      chk("s_dn0b.ovf", 32'(bus_s.ovf), 32'd1);
      set_in(0, 0, 0, 0, 0); #1;
      chk("s_en0.tc", 32'(bus_s.tc), 32'd0);
      tick(); #1;
      chk("s_en0.q",  32'(bus_s.q),  32'd0);

      // final report
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
